// File: rtl/aes128_word_loader.sv
// aes128_word_loader: word-stream front end for an AES-128 core.
// Assembles key/plaintext groups of four 32-bit words into the core operand
// registers, holds them for the fixed core latency, captures the ciphertext
// and the decrypt result, then streams the ciphertext back out as four words
// with a round-trip check flag and a saturating error counter.
module aes128_word_loader #(
   parameter int          LATENCY     = 24,     // core latency in clk edges, 1..255
   parameter logic [15:0] ERR_RST_VAL = 16'h0   // reset value of the error counter
) (
   input  logic        clk,
   input  logic        reset,          // asynchronous, active low
   // word input stream
   input  logic [31:0] in_data,
   input  logic        in_sel,         // 1 = key group, 0 = plaintext group
   input  logic        in_valid,
   output logic        in_ready,
   // operands to the core
   output logic [31:0] key_0,
   output logic [31:0] key_1,
   output logic [31:0] key_2,
   output logic [31:0] key_3,
   output logic [31:0] plain_text_0,
   output logic [31:0] plain_text_1,
   output logic [31:0] plain_text_2,
   output logic [31:0] plain_text_3,
   // results from the core
   input  logic [31:0] cipher_text_0,
   input  logic [31:0] cipher_text_1,
   input  logic [31:0] cipher_text_2,
   input  logic [31:0] cipher_text_3,
   input  logic [31:0] decrypted_plain_text_0,
   input  logic [31:0] decrypted_plain_text_1,
   input  logic [31:0] decrypted_plain_text_2,
   input  logic [31:0] decrypted_plain_text_3,
   // ciphertext output stream
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_ok,
   output logic        busy,
   output logic [15:0] err_count
);

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_KEY,
      S_LOAD_PT,
      S_WAIT,
      S_OUT
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;       // word index, shared by load and output
   logic [7:0]        cnt_q, cnt_d;       // core latency countdown
   logic [3:0][31:0]  key_q, key_d;
   logic [3:0][31:0]  pt_q, pt_d;
   logic [3:0][31:0]  buf_q, buf_d;       // captured ciphertext
   logic              ok_q, ok_d;
   logic [15:0]       err_q, err_d;
   logic              in_ready_q, in_ready_d;

   logic              in_acc, out_acc;
   logic              key_wr, pt_wr;
   logic [1:0]        wr_idx;
   logic              dec_match;
   logic [3:0][31:0]  dec_w;

   assign in_acc  = in_valid & in_ready_q;
   assign out_acc = out_valid & out_ready;

   assign dec_w = {decrypted_plain_text_3, decrypted_plain_text_2,
                   decrypted_plain_text_1, decrypted_plain_text_0};
   assign dec_match = (dec_w == pt_q);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (in_acc) state_d = in_sel ? S_LOAD_KEY : S_LOAD_PT;
         S_LOAD_KEY: if (in_acc && idx_q == 2'd3) state_d = S_IDLE;
         S_LOAD_PT:  if (in_acc && idx_q == 2'd3) state_d = S_WAIT;
         S_WAIT:     if (cnt_q == 8'd0) state_d = S_OUT;
         S_OUT:      if (out_acc && idx_q == 2'd3) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output decode; in_ready is registered off the next state so it tracks it
   always_comb begin
      out_valid  = (state_q == S_OUT);
      busy       = (state_q != S_IDLE);
      out_data   = out_valid ? buf_q[idx_q] : 32'h0;
      out_ok     = out_valid & ok_q;
      in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_KEY) ||
                   (state_d == S_LOAD_PT);
   end

   // Datapath next-state: word writes, latency countdown, capture, output index
   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      key_d = key_q;
      pt_d  = pt_q;
      buf_d = buf_q;
      ok_d  = ok_q;
      err_d = err_q;

      // group type is decided by the first word only; later words follow the state
      wr_idx = (state_q == S_IDLE) ? 2'd0 : idx_q;
      key_wr = in_acc && ((state_q == S_LOAD_KEY) || (state_q == S_IDLE && in_sel));
      pt_wr  = in_acc && ((state_q == S_LOAD_PT)  || (state_q == S_IDLE && !in_sel));

      if (key_wr) key_d[wr_idx] = in_data;
      if (pt_wr)  pt_d[wr_idx]  = in_data;
      if (in_acc) idx_d = wr_idx + 2'd1;

      if (state_q == S_LOAD_PT && in_acc && idx_q == 2'd3) cnt_d = LAT_M1;

      if (state_q == S_WAIT) begin
         if (cnt_q == 8'd0) begin
            buf_d = {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};
            ok_d  = dec_match;
            if (!dec_match && err_q != 16'hFFFF) err_d = err_q + 16'd1;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end

      if (out_acc) idx_d = idx_q + 2'd1;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q      <= 2'd0;
         cnt_q      <= 8'd0;
         key_q      <= '0;
         pt_q       <= '0;
         buf_q      <= '0;
         ok_q       <= 1'b0;
         err_q      <= ERR_RST_VAL;
         in_ready_q <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         key_q      <= key_d;
         pt_q       <= pt_d;
         buf_q      <= buf_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign err_count    = err_q;
   assign key_0        = key_q[0];
   assign key_1        = key_q[1];
   assign key_2        = key_q[2];
   assign key_3        = key_q[3];
   assign plain_text_0 = pt_q[0];
   assign plain_text_1 = pt_q[1];
   assign plain_text_2 = pt_q[2];
   assign plain_text_3 = pt_q[3];

endmodule

// File: doc/aes128_word_loader.md
# aes128_word_loader

Upstream/downstream wrapper for `aes128_top`. It accepts key and plaintext as a 32-bit word stream with valid/ready handshake and assembles them into the `key_0..3` and `plain_text_0..3` registers. It holds them stable for a fixed core latency, then captures `cipher_text_0..3` and `decrypted_plain_text_0..3`. It returns the ciphertext as a 4-word output stream and flags any round-trip mismatch.

## Interface
- `LATENCY`, default 24: clk edges from the registered operands updating to both core outputs being valid; legal range 1..255.
- `clk` input 1: single clock; all registers update on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_data` input 32: key or plaintext word.
- `in_sel` input 1: group type, 1 = key, 0 = plaintext; sampled only on the first word of a group.
- `in_valid` input 1: `in_data`/`in_sel` valid.
- `in_ready` output 1: word accepted on an edge where `in_valid && in_ready`.
- `key_0..key_3` output 32 each: registered key words to the core.
- `plain_text_0..plain_text_3` output 32 each: registered plaintext words to the core.
- `cipher_text_0..3` input 32 each: core ciphertext.
- `decrypted_plain_text_0..3` input 32 each: core decrypt result.
- `out_data` output 32: ciphertext word.
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: word consumed on an edge where `out_valid && out_ready`.
- `out_ok` output 1: round-trip check for the current block; 1 = decrypted equals plaintext. Valid while `out_valid`.
- `busy` output 1: high in every state except IDLE.
- `err_count` output 16: saturating count of blocks with `out_ok` = 0.

## Operation
- **States:** IDLE, LOAD_KEY, LOAD_PT, WAIT, OUT.
- **Word order:** word 0 of a group goes to `_0` (bits 31:0 of the 128-bit value); word 3 goes to `_3`.
- **IDLE:**
  - The first accepted word writes slot 0 and sets the 2-bit word index to 1.
  - With `in_sel`=1 the next state is LOAD_KEY; otherwise LOAD_PT.
  - `in_sel` on words 1..3 is ignored.
- **Word writes:** each accepted word writes directly into the selected key or plaintext output register. Registers not yet written keep their prior value.
- **LOAD_KEY:** after word 3 is accepted, return to IDLE. Key registers persist across any number of plaintext blocks.
- **LOAD_PT:** after word 3 is accepted, enter WAIT and load the 8-bit counter with LATENCY-1.
- **WAIT:**
  - `in_ready` = 0.
  - Counter decrements each edge.
  - On the edge where the counter equals 0:
    - Capture the 128-bit cipher into the output buffer.
    - Set the ok flag to (`decrypted_plain_text_0..3` == `plain_text_0..3`).
    - Enter OUT.
  - If ok = 0, `err_count` increments on that same edge, saturating at 16'hFFFF.
- **OUT:**
  - `out_valid` = 1 and `out_data` = buffered word[index], starting at index 0.
  - Index advances on each consumed word.
  - After word 3 is consumed, go to IDLE.
- **Operand stability:** key and plaintext registers never change during WAIT or OUT.
- **Stalls:** stalls on `in_valid` or `out_ready` of any length are legal. Partial groups wait indefinitely.
- **Reset mid-operation:** any state returns to IDLE and discards the partial group or buffered block.

## Timing
- **Reset values:**
  - All key, plaintext and buffer registers = 0.
  - `out_valid` = 0, `out_data` = 0, `out_ok` = 0, `busy` = 0, `err_count` = 0, word index = 0.
  - `in_ready` = 0; it rises on the first clk edge after reset deasserts.
- **`in_ready`:** 1 in IDLE, LOAD_KEY and LOAD_PT; 0 in WAIT and OUT. Registered, updated on the same edge as the state.
- **Core latency:** `plain_text_3` updates on edge E (acceptance of word 3). Capture happens on edge E+LATENCY, and `out_valid` rises just after that edge.
- **Throughput:** with zero stalls, one block costs 4 + LATENCY + 4 cycles.
- **Input gap:** when word 3 of OUT is consumed on edge F, `in_ready` is 1 after F. There is no dead cycle.
- **`out_data`/`out_ok` stability:** both hold stable while `out_valid && !out_ready`.
- **Reset assertion:** asynchronous; outputs reach reset values without waiting for clk.

## Test plan
- **FIPS-197 vector:**
  - Stimulus:
    - Key group (`in_sel`=1): 0x0c0d0e0f, 0x08090a0b, 0x04050607, 0x00010203.
    - Plaintext group: 0xccddeeff, 0x8899aabb, 0x44556677, 0x00112233.
  - Response:
    - `out_data` sequence 0x70b4c55a, 0xd8cdb780, 0x6a7b0430, 0x69c4e0d8.
    - `out_ok` = 1 and `err_count` = 0.
    - `out_valid` rises exactly LATENCY edges after the last plaintext word is accepted.
- **Back-to-back plaintext blocks, key loaded once:** two blocks each give the correct 4 words. `in_ready` is 0 throughout WAIT/OUT, and `key_0..3` are unchanged.
- **Random `in_valid`/`out_ready` stalls** (30% idle): identical `out_data` sequence to the unstalled run, and `out_data` is held during every stall.
- **Forced mismatch** (model drives a wrong `decrypted_plain_text_2`): `out_ok` = 0 and `err_count` = 1. A second mismatched block gives 2. Preload 0xFFFE plus 3 errors: the count stays at 0xFFFF.
- **Reset after 2 plaintext words, and again in OUT after 1 word consumed:**
  - Immediately `busy` = 0, `out_valid` = 0, and all registers = 0.
  - A fresh full key + plaintext sequence then produces the FIPS-197 ciphertext.
